if_prefetch: RTL

//  Instruction-fetch front end of the 3-stage RISC-V pipeline; sits directly upstream of decode/execute.

---
 rtl/if_prefetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end with prefetch FIFO and redirect flush; IF_PERF_EN adds perf counters
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  logic [31:0] pc;
  logic [CW-1:0] count, outstanding, drop_cnt, out_next;
  logic [AW-1:0] head, tail, tag_wr, tag_rd;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] tag_q [DEPTH];
  logic req_fire, rsp_fire, push, pop;
  // credit check, handshakes and the next outstanding count
  always_comb begin
    imem_req_valid = !reset && !redirect_valid && (count + outstanding < CAP);
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && outstanding != '0;
    push = rsp_fire && drop_cnt == '0 && !redirect_valid;
    pop = if_valid && if_ready && !redirect_valid;
    out_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
  end
  assign imem_req_addr = pc;
  assign if_valid = count != '0;
  assign if_instr = instr_q[head];
  assign if_pc = pc_q[head];
  // PC generation, tag queue, prefetch FIFO and stale-response accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      head <= '0;
      tail <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      outstanding <= out_next;
      if (req_fire) begin
        tag_q[tag_wr] <= pc;
        tag_wr <= tag_wr + 1'b1;
      end
      if (rsp_fire) tag_rd <= tag_rd + 1'b1;
      if (redirect_valid) begin
        pc <= redirect_pc & ~32'h3;
        head <= '0;
        tail <= '0;
        count <= '0;
        drop_cnt <= out_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          instr_q[tail] <= imem_rsp_data;
          pc_q[tail] <= tag_q[tag_rd];
          tail <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef IF_PERF_EN
  // decode handshakes and everything a redirect throws away (flushed entries plus stale responses)
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'(count) + 32'(rsp_fire);
      else if (rsp_fire && drop_cnt != '0) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule
